mul_ctrl: RTL and testbench

Sequencing controller for the RV64M multiply unit in the EX stage. It accepts one multiply op per handshake and registers the operands. It then drives the combinational Booth/Wallace array multiplier (wallace_mul) for a fixed multicycle window, selects and formats the 64-bit result, and holds it until the consumer takes it. A one-entry product cache lets back-to-back MULH*/MUL pairs on identical operands skip the array.

---
 rtl/mul_ctrl_pkg.sv | 55 +++++
 rtl/mul_ctrl_if.sv | 27 ++
 rtl/mul_ctrl_wallace.sv | 21 ++
 rtl/mul_ctrl.sv | 118 +++++++++++
 tb/tb_mul_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_ctrl_pkg.sv
// Shared types and op decoding for the RV64M multiply sequencer.
package mul_ctrl_pkg;

  localparam int REG_W  = 64;
  localparam int PROD_W = 2 * REG_W;
  localparam int CNT_W  = 4;

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [PROD_W-1:0] prod_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic rs1;
    logic rs2;
  } sign_pair_t;

  typedef struct packed {
    reg_t       rs1;
    reg_t       rs2;
    sign_pair_t sgn;
  } operands_t;

  function automatic logic op_legal(logic [2:0] op);
    return op <= OP_MULW;
  endfunction

  // Ops that only use the low product bits do not care about operand signedness.
  function automatic logic op_low_only(logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULW);
  endfunction

  function automatic sign_pair_t op_signs(logic [2:0] op);
    sign_pair_t s;
    case (op)
      OP_MULHSU: s = '{rs1: 1'b1, rs2: 1'b0};
      OP_MULHU:  s = '{rs1: 1'b0, rs2: 1'b0};
      default:   s = '{rs1: 1'b1, rs2: 1'b1};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Request/result handshake bundle between the EX stage and the multiply sequencer.
interface mul_ctrl_if
  import mul_ctrl_pkg::*;
();

  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  reg_t       in_rs1;
  reg_t       in_rs2;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  reg_t       out_data;
  logic       busy;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, flush, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, flush, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface

// File: rtl/mul_ctrl_wallace.sv
// Combinational 64x64 array multiplier with per-operand signedness; 128-bit product.
module wallace_mul
  import mul_ctrl_pkg::*;
(
  input  reg_t  a,
  input  reg_t  b,
  input  logic  a_signed,
  input  logic  b_signed,
  output prod_t product
);

  // Sign-extending each operand to the product width makes the truncated
  // unsigned product equal the signed/mixed product modulo 2^128.
  prod_t a_ext;
  prod_t b_ext;

  assign a_ext   = {{REG_W{a_signed & a[REG_W-1]}}, a};
  assign b_ext   = {{REG_W{b_signed & b[REG_W-1]}}, b};
  assign product = a_ext * b_ext;

endmodule

// File: rtl/mul_ctrl.sv
// Multicycle sequencer around wallace_mul with a one-entry product cache for
// back-to-back MULH*/MUL pairs on identical operands.
module mul_ctrl
  import mul_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  mul_ctrl_if.slave    bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  operands_t        opnd_q;
  reg_t             out_data_q;
  logic             cache_valid;
  operands_t        cache_key;
  prod_t            cache_prod;
  prod_t            product;

  logic       accept;
  logic       legal;
  logic       hit;
  logic       calc_last;
  sign_pair_t in_sgn;

  assign bus.in_ready  = !bus.flush &&
                         ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign legal         = op_legal(bus.in_op);
  assign in_sgn        = op_signs(bus.in_op);
  assign hit           = cache_valid &&
                         (bus.in_rs1 == cache_key.rs1) && (bus.in_rs2 == cache_key.rs2) &&
                         (op_low_only(bus.in_op) || (in_sgn == cache_key.sgn));
  // A flush in the final window cycle must not leave a product in the cache.
  assign calc_last     = (state == ST_CALC) && !bus.flush && (cnt == LAST_CNT);

  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state != ST_IDLE);
  assign bus.out_data  = out_data_q;

  wallace_mul u_wallace_mul (
    .a        (opnd_q.rs1),
    .b        (opnd_q.rs2),
    .a_signed (opnd_q.sgn.rs1),
    .b_signed (opnd_q.sgn.rs2),
    .product  (product)
  );

  function automatic reg_t format_result(logic [2:0] op, prod_t p);
    reg_t r;
    case (op)
      OP_MUL:                       r = p[REG_W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: r = p[PROD_W-1:REG_W];
      OP_MULW:                      r = {{32{p[31]}}, p[31:0]};
      default:                      r = '0;
    endcase
    return r;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      cache_valid <= 1'b0;
      out_data_q  <= '0;
    end else if (accept) begin
      cnt <= '0;
      if (!legal) begin
        state      <= ST_DONE;
        out_data_q <= '0;
      end else if (hit) begin
        state      <= ST_DONE;
        out_data_q <= format_result(bus.in_op, cache_prod);
      end else begin
        state <= ST_CALC;
      end
    end else begin
      case (state)
        ST_CALC: begin
          if (bus.flush) begin
            state <= ST_IDLE;
          end else if (calc_last) begin
            cache_valid <= 1'b1;
            out_data_q  <= format_result(op_q, product);
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.flush || bus.out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: operand latches and cache payload are deliberately not reset;
  // cache_valid and the FSM guarantee they are never consumed before written.
  always_ff @(posedge clock) begin
    if (!reset && accept) begin
      op_q   <= bus.in_op;
      opnd_q <= '{rs1: bus.in_rs1, rs2: bus.in_rs2, sgn: in_sgn};
    end
    if (!reset && calc_last) begin
      cache_key  <= opnd_q;
      cache_prod <= product;
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Directed self-checking bench for mul_ctrl with MUL_CYCLES = 2.
module tb_mul_ctrl;
  import mul_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  mul_ctrl_if bus ();

  mul_ctrl #(.MUL_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Offers an op and returns 1 ns after the edge that accepts it.
  task automatic drive_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int budget;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    budget = 0;
    while (!bus.in_ready && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    if (!bus.in_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: in_ready got %b want 1", bus.in_ready);
    end
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts cycles from the accept edge until out_valid is seen at a negedge.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!bus.out_valid && lat < 20);
    vectors++;
    if (!bus.out_valid) begin
      miscompares++;
      $display("FAIL valid_timeout: out_valid got %b want 1", bus.out_valid);
    end
  endtask

  // Full transaction with out_ready=1; returns latency and delivered data.
  task automatic do_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [63:0] data);
    drive_op(op, a, b);
    wait_valid(lat);
    data = bus.out_data;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.out_data !== 64'd0) begin miscompares++; $display("FAIL rst_out_data: got %h want 0", bus.out_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic_mul();
    drive_op(OP_MUL, 64'd3, 64'd5);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_in_ready_c%0d: got %b want 0", c, bus.in_ready); end
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid_c%0d: got %b want 0", c, bus.out_valid); end
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_c%0d: got %b want 1", c, bus.busy); end
    end
    @(negedge clock);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid_c3: got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_data !== 64'd15) begin miscompares++; $display("FAIL basic_data: got %h want %h", bus.out_data, 64'd15); end
    @(negedge clock);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_idle_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_mulh_family();
    int lat;
    logic [63:0] d;
    do_op(OP_MULH, '1, '1, lat, d);
    vectors++; if (d !== 64'h0) begin miscompares++; $display("FAIL mulh_data: got %h want %h", d, 64'h0); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL mulh_lat: got %0d want 3", lat); end
    do_op(OP_MULHU, '1, '1, lat, d);
    vectors++; if (d !== 64'hFFFF_FFFF_FFFF_FFFE) begin miscompares++; $display("FAIL mulhu_data: got %h want fffffffffffffffe", d); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL mulhu_lat: got %0d want 3", lat); end
    do_op(OP_MULHSU, '1, 64'd2, lat, d);
    vectors++; if (d !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL mulhsu_data: got %h want ffffffffffffffff", d); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL mulhsu_lat: got %0d want 3", lat); end
  endtask

  task automatic test_mulw();
    int lat;
    logic [63:0] d;
    do_op(OP_MULW, 64'h7FFF_FFFF, 64'd2, lat, d);
    vectors++; if (d !== 64'hFFFF_FFFF_FFFF_FFFE) begin miscompares++; $display("FAIL mulw_neg_data: got %h want fffffffffffffffe", d); end
    do_op(OP_MULW, 64'h1_0000_0003, 64'd4, lat, d);
    vectors++; if (d !== 64'h0000_0000_0000_000C) begin miscompares++; $display("FAIL mulw_trunc_data: got %h want 000000000000000c", d); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL mulw_trunc_lat: got %0d want 3", lat); end
    do_op(OP_MULW, 64'h1_0000_0003, 64'd4, lat, d);
    vectors++; if (d !== 64'h0000_0000_0000_000C) begin miscompares++; $display("FAIL mulw_hit_data: got %h want 000000000000000c", d); end
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL mulw_hit_lat: got %0d want 1", lat); end
  endtask

  task automatic test_back_to_back();
    logic [63:0]  a, b;
    logic [127:0] p;
    int lat;
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'h0FED_CBA9_8765_4321;
    // Both operands are positive, so the unsigned 128-bit product is also the signed one.
    p = {64'd0, a} * {64'd0, b};
    drive_op(OP_MULH, a, b);
    wait_valid(lat);
    vectors++; if (bus.out_data !== p[127:64]) begin miscompares++; $display("FAIL b2b_mulh_data: got %h want %h", bus.out_data, p[127:64]); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL b2b_mulh_lat: got %0d want 3", lat); end
    // Offer the MUL while the MULH result is still being taken.
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_rs1 = a; bus.in_rs2 = b;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready_done: got %b want 1", bus.in_ready); end
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    @(negedge clock);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_hit_valid: got %b want 1", bus.out_valid); end
    vectors++; if (bus.out_data !== p[63:0]) begin miscompares++; $display("FAIL b2b_hit_data: got %h want %h", bus.out_data, p[63:0]); end
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_rs1 = a; bus.in_rs2 = 64'd7;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    wait_valid(lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL b2b_miss_lat: got %0d want 3", lat); end
    vectors++; if (bus.out_data !== 64'h7F6E_5D4C_3B2A_1890) begin miscompares++; $display("FAIL b2b_miss_data: got %h want 7f6e5d4c3b2a1890", bus.out_data); end
    @(posedge clock);
    #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    drive_op(OP_MUL, 64'd9, 64'd11);
    wait_valid(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid_%0d: got %b want 1", c, bus.out_valid); end
      vectors++; if (bus.out_data !== 64'd99) begin miscompares++; $display("FAIL hold_data_%0d: got %h want %h", c, bus.out_data, 64'd99); end
      vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready_%0d: got %b want 0", c, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_single_xfer_%0d: got %b want 0", c, bus.out_valid); end
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    logic [63:0] d;
    drive_op(OP_MUL, 64'd13, 64'd17);
    @(negedge clock);
    @(negedge clock);
    // Final CALC cycle: flush, and offer an op that must not be taken.
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = OP_MUL; bus.in_rs1 = 64'd1; bus.in_rs2 = 64'd1;
    #1;
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b want 0", bus.in_ready); end
    @(posedge clock);
    #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.out_valid) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL flush_no_valid: got %0d valid cycles want 0", seen); end
    @(posedge clock);
    #1;
    do_op(OP_MUL, 64'd13, 64'd17, lat, d);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL flush_retry_lat: got %0d want 3", lat); end
    vectors++; if (d !== 64'd221) begin miscompares++; $display("FAIL flush_retry_data: got %h want %h", d, 64'd221); end
  endtask

  task automatic test_reset_mid_and_illegal();
    int lat;
    logic [63:0] d;
    bus.out_ready = 1'b0;
    drive_op(OP_MUL, 64'd21, 64'd2);
    wait_valid(lat);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready: got %b want 1", bus.in_ready); end
    do_op(OP_MUL, 64'd21, 64'd2, lat, d);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL rstmid_retry_lat: got %0d want 3", lat); end
    vectors++; if (d !== 64'd42) begin miscompares++; $display("FAIL rstmid_retry_data: got %h want %h", d, 64'd42); end
    do_op(3'd7, 64'd21, 64'd2, lat, d);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL illegal_lat: got %0d want 1", lat); end
    vectors++; if (d !== 64'd0) begin miscompares++; $display("FAIL illegal_data: got %h want 0", d); end
    do_op(OP_MUL, 64'd21, 64'd2, lat, d);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL illegal_cache_kept_lat: got %0d want 1", lat); end
    vectors++; if (d !== 64'd42) begin miscompares++; $display("FAIL illegal_cache_kept_data: got %h want %h", d, 64'd42); end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_MUL;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic_mul();
    test_mulh_family();
    test_mulw();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_and_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
